// File: rtl/cpu_regfile_scoreboard_if.sv
// Bus bundle for cpu_regfile_scoreboard: write/reserve ports, packed read ports and
// the register dump stream. The DUT takes the slave modport; the CPU side takes master.
interface cpu_regfile_scoreboard_if #(
    parameter int NUMBER_OF_REGISTERS  = 8,
    parameter int DATA_WIDTH           = 8,
    parameter int NUMBER_OF_READ_PORTS = 2
);
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);

    logic                                       write_enable_in;
    logic [AW-1:0]                              write_register_address_in;
    logic signed [DATA_WIDTH-1:0]               write_data_in;
    logic                                       reserve_enable_in;
    logic [AW-1:0]                              reserve_register_address_in;
    logic [NUMBER_OF_READ_PORTS*AW-1:0]         read_register_address_in;
    logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0] read_data_out;
    logic [NUMBER_OF_READ_PORTS-1:0]            read_busy_out;

    // Dump stream: a beat transfers on any posedge where dump_valid_out and
    // dump_ready_in are both high. Once valid rises it stays high, and address/data
    // stay frozen, until that beat transfers; ready may toggle freely.
    logic                                       dump_start_in;
    logic                                       dump_valid_out;
    logic                                       dump_ready_in;
    logic [AW-1:0]                              dump_address_out;
    logic signed [DATA_WIDTH-1:0]               dump_data_out;
    logic                                       dump_active_out;
    logic                                       dump_done_out;
    logic                                       dump_state_out;

    modport master (
        output write_enable_in, write_register_address_in, write_data_in,
        output reserve_enable_in, reserve_register_address_in,
        output read_register_address_in,
        input  read_data_out, read_busy_out,
        output dump_start_in, dump_ready_in,
        input  dump_valid_out, dump_address_out, dump_data_out,
        input  dump_active_out, dump_done_out, dump_state_out
    );

    modport slave (
        input  write_enable_in, write_register_address_in, write_data_in,
        input  reserve_enable_in, reserve_register_address_in,
        input  read_register_address_in,
        output read_data_out, read_busy_out,
        input  dump_start_in, dump_ready_in,
        output dump_valid_out, dump_address_out, dump_data_out,
        output dump_active_out, dump_done_out, dump_state_out
    );
endinterface

// File: rtl/cpu_regfile_scoreboard.sv
// Register file with per-register busy (scoreboard) bits and a valid/ready dump stream.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module cpu_regfile_scoreboard #(
    parameter int NUMBER_OF_REGISTERS  = 8,
    parameter int DATA_WIDTH           = 8,
    parameter int NUMBER_OF_READ_PORTS = 2
) (
    input logic                     clock_in,
    input logic                     reset_in,
    cpu_regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NUMBER_OF_REGISTERS);
    localparam logic [AW-1:0] LAST_INDEX = AW'(NUMBER_OF_REGISTERS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_t;

    logic signed [DATA_WIDTH-1:0] regs [NUMBER_OF_REGISTERS];
    logic [NUMBER_OF_REGISTERS-1:0] busy;

    // Register 0 is never assigned outside reset, so it stays zero and never busy.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 1; i < NUMBER_OF_REGISTERS; i++) begin
                if (bus.write_enable_in && bus.write_register_address_in == AW'(i)) begin
                    regs[i] <= bus.write_data_in;
                end
                // A reserve outranks a same-cycle write: the producer it announces is still pending.
                if (bus.reserve_enable_in && bus.reserve_register_address_in == AW'(i)) begin
                    busy[i] <= 1'b1;
                end else if (bus.write_enable_in && bus.write_register_address_in == AW'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    logic [AW-1:0] read_address [NUMBER_OF_READ_PORTS];
    logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [NUMBER_OF_READ_PORTS-1:0] read_busy;

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int k = 0; k < NUMBER_OF_READ_PORTS; k++) begin
            read_address[k] = bus.read_register_address_in[k*AW +: AW];
            read_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[read_address[k]];
            read_busy[k] = busy[read_address[k]];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; reset suppresses it so reads stay zero.
            if (!reset_in && bus.write_enable_in && bus.write_register_address_in != '0
                && bus.write_register_address_in == read_address[k]) begin
                read_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.write_data_in;
                read_busy[k] = bus.reserve_enable_in
                               && bus.reserve_register_address_in == read_address[k];
            end
`endif
        end
    end

    assign bus.read_data_out = read_data;
    assign bus.read_busy_out = read_busy;

    dump_state_t dump_state, dump_state_next;
    logic [AW-1:0] dump_index, dump_index_next;
    logic signed [DATA_WIDTH-1:0] dump_data_q, dump_data_next;
    logic dump_done_q, dump_done_next;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            dump_state  <= IDLE;
            dump_index  <= '0;
            dump_data_q <= '0;
            dump_done_q <= 1'b0;
        end else begin
            dump_state  <= dump_state_next;
            dump_index  <= dump_index_next;
            dump_data_q <= dump_data_next;
            dump_done_q <= dump_done_next;
        end
    end

    // The held beat is captured from the array on the same edge that moves the index,
    // so later writes cannot disturb a stalled beat.
    always_comb begin
        dump_state_next = dump_state;
        dump_index_next = dump_index;
        dump_data_next  = dump_data_q;
        dump_done_next  = 1'b0;
        case (dump_state)
            IDLE: begin
                if (bus.dump_start_in) begin
                    dump_state_next = STREAM;
                    dump_index_next = '0;
                    dump_data_next  = regs[0];
                end
            end
            STREAM: begin
                if (bus.dump_ready_in) begin
                    if (dump_index == LAST_INDEX) begin
                        dump_state_next = IDLE;
                        dump_done_next  = 1'b1;
                    end else begin
                        dump_index_next = dump_index + AW'(1);
                        dump_data_next  = regs[dump_index + AW'(1)];
                    end
                end
            end
            default: dump_state_next = IDLE;
        endcase
    end

    assign bus.dump_valid_out   = (dump_state == STREAM);
    assign bus.dump_active_out  = (dump_state != IDLE);
    assign bus.dump_address_out = dump_index;
    assign bus.dump_data_out    = dump_data_q;
    assign bus.dump_done_out    = dump_done_q;
    assign bus.dump_state_out   = dump_state;
endmodule

// File: tb/tb_cpu_regfile_scoreboard.sv
// Self-checking bench for cpu_regfile_scoreboard: directed vector table, hand-written
// dump/reset sequences and randomized traffic against a behavioural model.
module tb_cpu_regfile_scoreboard;
    localparam int NR = 8;
    localparam int DW = 8;
    localparam int NP = 2;
    localparam int AW = $clog2(NR);

    logic clock_in = 1'b0;
    logic reset_in;

    cpu_regfile_scoreboard_if #(
        .NUMBER_OF_REGISTERS(NR), .DATA_WIDTH(DW), .NUMBER_OF_READ_PORTS(NP)
    ) bus ();

    cpu_regfile_scoreboard #(
        .NUMBER_OF_REGISTERS(NR), .DATA_WIDTH(DW), .NUMBER_OF_READ_PORTS(NP)
    ) dut (
        .clock_in(clock_in),
        .reset_in(reset_in),
        .bus(bus)
    );

    // ---------------- clock ----------------
    always #5 clock_in = ~clock_in;

    // ---------------- model / scoreboard ----------------
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    bit            m_dump_on;
    int            m_dump_idx;
    bit            m_done;
    logic [DW-1:0] exp_q [$];
    int            vectors;
    int            miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_dump_on  = 1'b0;
        m_dump_idx = 0;
        m_done     = 1'b0;
        exp_q.delete();
    endtask

    // Applies the inputs held across the edge; register contents are pre-edge here.
    task automatic model_edge();
        int wa;
        int ra;
        m_done = 1'b0;
        if (reset_in) begin
            model_reset();
            return;
        end
        if (!m_dump_on) begin
            if (bus.dump_start_in) begin
                m_dump_on  = 1'b1;
                m_dump_idx = 0;
                exp_q.push_back(m_regs[0]);
            end
        end else if (bus.dump_ready_in) begin
            void'(exp_q.pop_front());
            if (m_dump_idx == NR - 1) begin
                m_dump_on = 1'b0;
                m_done    = 1'b1;
            end else begin
                m_dump_idx++;
                exp_q.push_back(m_regs[m_dump_idx]);
            end
        end
        wa = int'(bus.write_register_address_in);
        ra = int'(bus.reserve_register_address_in);
        if (bus.write_enable_in && wa != 0) begin
            m_regs[wa] = bus.write_data_in;
            m_busy[wa] = 1'b0;
        end
        if (bus.reserve_enable_in && ra != 0) m_busy[ra] = 1'b1;
    endtask

    function automatic void exp_read(input int a, output logic [DW-1:0] d, output bit b);
        d = m_regs[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (!reset_in && bus.write_enable_in && int'(bus.write_register_address_in) != 0
            && int'(bus.write_register_address_in) == a) begin
            d = bus.write_data_in;
            b = bus.reserve_enable_in && int'(bus.reserve_register_address_in) == a;
        end
`endif
    endfunction

    task automatic check_reads();
        logic [DW-1:0] d;
        bit b;
        int a;
        for (int k = 0; k < NP; k++) begin
            a = int'(bus.read_register_address_in[k*AW +: AW]);
            exp_read(a, d, b);
            check($sformatf("read_data[%0d] r%0d", k, a), bus.read_data_out[k*DW +: DW], d);
            check($sformatf("read_busy[%0d] r%0d", k, a), bus.read_busy_out[k], b);
        end
    endtask

    task automatic check_dump();
        check("dump_valid", bus.dump_valid_out, m_dump_on);
        check("dump_active", bus.dump_active_out, m_dump_on);
        check("dump_done", bus.dump_done_out, m_done);
        if (m_dump_on) begin
            check("dump_address", bus.dump_address_out, m_dump_idx);
            check("dump_data", $unsigned(bus.dump_data_out), exp_q[0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock_in);
        model_edge();
        #1;
        check_dump();
    endtask

    task automatic idle_inputs();
        bus.write_enable_in             = 1'b0;
        bus.write_register_address_in   = '0;
        bus.write_data_in               = '0;
        bus.reserve_enable_in           = 1'b0;
        bus.reserve_register_address_in = '0;
        bus.dump_start_in               = 1'b0;
        bus.dump_ready_in               = 1'b0;
    endtask

    task automatic set_read(input int p, input int a);
        bus.read_register_address_in[p*AW +: AW] = AW'(a);
    endtask

    task automatic drive_write(input int a, input int d);
        bus.write_enable_in           = 1'b1;
        bus.write_register_address_in = AW'(a);
        bus.write_data_in             = DW'(d);
    endtask

    typedef struct {
        bit we; int waddr; int wdata;
        bit rsv; int raddr;
        int rd0; int rd1;
        int exp_d0; bit exp_b0;
        int exp_d1; bit exp_b1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] beat4;
        int dones;
        bit wrote44;

        vectors = 0;
        miscompares = 0;
        //              we wa wdata rsv ra  rd0 rd1  d0    b0  d1    b1
        tbl[0] = '{1, 3, 'h7F, 0, 0,  3, 0,  'h7F, 0, 'h00, 0};
        tbl[1] = '{1, 0, 'h55, 0, 0,  0, 3,  'h00, 0, 'h7F, 0};
        tbl[2] = '{0, 0, 0,    1, 5,  5, 3,  'h00, 1, 'h7F, 0};
        tbl[3] = '{0, 0, 0,    0, 0,  5, 1,  'h00, 1, 'h00, 0};
        tbl[4] = '{1, 5, -12,  0, 0,  5, 5,  'hF4, 0, 'hF4, 0};
        tbl[5] = '{1, 2, 'h11, 1, 2,  2, 5,  'h11, 1, 'hF4, 0};
        tbl[6] = '{1, 0, 'h33, 1, 0,  0, 2,  'h00, 0, 'h11, 1};
        tbl[7] = '{1, 2, 'h22, 0, 0,  2, 7,  'h22, 0, 'h00, 0};
        tbl[8] = '{1, 7, -128, 0, 0,  7, 6,  'h80, 0, 'h00, 0};
        tbl[9] = '{1, 6, 'h10, 0, 0,  6, 7,  'h10, 0, 'h80, 0};

        // ---------------- reset ----------------
        reset_in = 1'b1;
        idle_inputs();
        bus.read_register_address_in = '0;
        model_reset();
        tick();
        tick();
        reset_in = 1'b0;
        set_read(0, 3);
        set_read(1, 7);
        #1;
        check_reads();
        check("reset_dump_address", bus.dump_address_out, 0);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 10; i++) begin
            bus.write_enable_in             = tbl[i].we;
            bus.write_register_address_in   = AW'(tbl[i].waddr);
            bus.write_data_in               = DW'(tbl[i].wdata);
            bus.reserve_enable_in           = tbl[i].rsv;
            bus.reserve_register_address_in = AW'(tbl[i].raddr);
            tick();
            idle_inputs();
            set_read(0, tbl[i].rd0);
            set_read(1, tbl[i].rd1);
            #1;
            check($sformatf("vec%0d data0", i), bus.read_data_out[0 +: DW], tbl[i].exp_d0);
            check($sformatf("vec%0d busy0", i), bus.read_busy_out[0], tbl[i].exp_b0);
            check($sformatf("vec%0d data1", i), bus.read_data_out[DW +: DW], tbl[i].exp_d1);
            check($sformatf("vec%0d busy1", i), bus.read_busy_out[1], tbl[i].exp_b1);
        end

        // ---------------- same-cycle write visibility on port 1 ----------------
        drive_write(6, 'h2A);
        bus.reserve_enable_in           = 1'b1;
        bus.reserve_register_address_in = AW'(6);
        set_read(0, 7);
        set_read(1, 6);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass r6 data", bus.read_data_out[DW +: DW], 'h2A);
        check("bypass r6 busy", bus.read_busy_out[1], 1);
`else
        check("no_bypass r6 data", bus.read_data_out[DW +: DW], 'h10);
        check("no_bypass r6 busy", bus.read_busy_out[1], 0);
`endif
        check("bypass r7 untouched", bus.read_data_out[0 +: DW], 'h80);
        tick();
        idle_inputs();
        #1;
        check("r6 after write data", bus.read_data_out[DW +: DW], 'h2A);
        check("r6 after write busy", bus.read_busy_out[1], 1);

        // ---------------- dump with stalls and a mid-dump write ----------------
        for (int r = 1; r < NR; r++) begin
            drive_write(r, r);
            tick();
        end
        idle_inputs();
        bus.dump_start_in = 1'b1;
        tick();
        bus.dump_start_in = 1'b0;
        dones = 0;
        wrote44 = 1'b0;
        beat4 = '0;
        for (int c = 0; c < 40; c++) begin
            bus.dump_ready_in = c[0];
            bus.dump_start_in = (c == 5);
            if (!wrote44 && m_dump_on && m_dump_idx == 2) begin
                drive_write(4, 'h44);
                wrote44 = 1'b1;
            end
            tick();
            bus.write_enable_in = 1'b0;
            if (bus.dump_done_out) dones++;
            if (bus.dump_valid_out && bus.dump_address_out == AW'(4)) beat4 = bus.dump_data_out;
        end
        idle_inputs();
        check("dump_done_count", dones, 1);
        check("dump_beat4_value", beat4, 'h44);

        // ---------------- reset in the middle of a dump ----------------
        bus.dump_start_in = 1'b1;
        bus.dump_ready_in = 1'b1;
        tick();
        bus.dump_start_in = 1'b0;
        for (int c = 0; c < 20 && m_dump_idx != 3; c++) tick();
        check("dump_index_at_reset", bus.dump_address_out, 3);
        reset_in = 1'b1;
        drive_write(3, 'h99);
        bus.reserve_enable_in           = 1'b1;
        bus.reserve_register_address_in = AW'(3);
        bus.dump_start_in               = 1'b1;
        #1;
        model_reset();
        check_dump();
        for (int r = 0; r < NR; r += NP) begin
            for (int k = 0; k < NP; k++) set_read(k, r + k);
            #1;
            check_reads();
        end
        tick();
        set_read(0, 3);
        #1;
        check_reads();
        reset_in = 1'b0;
        idle_inputs();
        #1;
        check_reads();
        bus.dump_start_in = 1'b1;
        tick();
        bus.dump_start_in = 1'b0;
        check("restart_address", bus.dump_address_out, 0);
        check("restart_valid", bus.dump_valid_out, 1);
        bus.dump_ready_in = 1'b1;
        for (int c = 0; c < 12; c++) tick();

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 400; c++) begin
            bus.write_enable_in             = 1'($urandom_range(0, 1));
            bus.write_register_address_in   = AW'($urandom_range(0, NR - 1));
            bus.write_data_in               = DW'($urandom_range(0, 255));
            bus.reserve_enable_in           = ($urandom_range(0, 3) == 0);
            bus.reserve_register_address_in = AW'($urandom_range(0, NR - 1));
            bus.dump_start_in               = ($urandom_range(0, 15) == 0);
            bus.dump_ready_in               = 1'($urandom_range(0, 1));
            for (int k = 0; k < NP; k++) set_read(k, $urandom_range(0, NR - 1));
            #1;
            check_reads();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
